// File: rtl/sp_rx_if.sv
// SP receive link bundle: serial strobes/data in, word handshake and status out.
// With SP_RX_PARITY_EN defined the bundle also carries rx_perr.
interface sp_rx_if #(parameter int WIDTH = 16);
   logic             sp_start;
   logic             sp_req;
   logic             sp_data;
   logic             rx_ack;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             overrun;
   logic             frame_err;
   logic             busy;
`ifdef SP_RX_PARITY_EN
   logic             rx_perr;
`endif

   // master: link/consumer side driving the receiver
   modport master (
      output sp_start, sp_req, sp_data, rx_ack,
      input  rx_data, rx_valid, overrun, frame_err, busy
`ifdef SP_RX_PARITY_EN
      , input rx_perr
`endif
   );

   // slave: the receiver itself
   modport slave (
      input  sp_start, sp_req, sp_data, rx_ack,
      output rx_data, rx_valid, overrun, frame_err, busy
`ifdef SP_RX_PARITY_EN
      , output rx_perr
`endif
   );
endinterface

// File: rtl/sp_rx.sv
// SP serial receiver: MSB-first deserialiser paced by delayed sp_req strobes.
// Optional even-parity bit per frame when SP_RX_PARITY_EN is defined.
module sp_rx #(
   parameter int WIDTH      = 16,
   parameter int SAMPLE_DLY = 2
) (
   input  logic    clk,
   input  logic    rst,
   sp_rx_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

`ifdef SP_RX_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t                state;
   logic [CW-1:0]         bit_cnt;
   logic [WIDTH-1:0]      sh;
   logic [WIDTH-1:0]      word;
   logic [SAMPLE_DLY-1:0] dly;
   logic                  samp;
   logic                  last;
   logic                  mid_word;

   assign samp = dly[SAMPLE_DLY-1];
   assign word = {sh[WIDTH-2:0], bus.sp_data};
   assign last = (bit_cnt == CW'(WIDTH - 1));
`ifdef SP_RX_PARITY_EN
   assign mid_word = ((state == SHIFT) && (bit_cnt != '0)) || (state == PAR);
`else
   assign mid_word = (state == SHIFT) && (bit_cnt != '0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         sh            <= '0;
         dly           <= '0;
         bus.rx_data   <= '0;
         bus.rx_valid  <= 1'b0;
         bus.overrun   <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.busy      <= 1'b0;
`ifdef SP_RX_PARITY_EN
         bus.rx_perr   <= 1'b0;
`endif
      end else begin
         bus.overrun   <= 1'b0;
         bus.frame_err <= 1'b0;
         if (bus.rx_ack && bus.rx_valid) bus.rx_valid <= 1'b0;

         // a start flushes strobes still in flight from the previous frame
         if (bus.sp_start) dly <= '0;
         else              dly <= (dly << 1) | SAMPLE_DLY'(bus.sp_req);

         if (bus.sp_start) begin
            bus.frame_err <= mid_word;
            state         <= SHIFT;
            bus.busy      <= 1'b1;
            bit_cnt       <= '0;
            sh            <= '0;
         end else if (samp) begin
            case (state)
               SHIFT: begin
                  sh      <= word;
                  bit_cnt <= bit_cnt + CW'(1);
                  if (last) begin
`ifdef SP_RX_PARITY_EN
                     state <= PAR;
`else
                     // later rx_valid write overrides the ack clear above
                     bus.rx_data  <= word;
                     bus.rx_valid <= 1'b1;
                     bus.overrun  <= bus.rx_valid && !bus.rx_ack;
                     state        <= IDLE;
                     bus.busy     <= 1'b0;
`endif
                  end
               end
`ifdef SP_RX_PARITY_EN
               PAR: begin
                  bus.rx_data  <= sh;
                  bus.rx_valid <= 1'b1;
                  bus.overrun  <= bus.rx_valid && !bus.rx_ack;
                  bus.rx_perr  <= (^sh) ^ bus.sp_data;
                  state        <= IDLE;
                  bus.busy     <= 1'b0;
               end
`endif
               default: ;
            endcase
         end
      end
   end
endmodule
